// File: rtl/afe_integrator_emulator.sv
// Forward model of the DAPHNE AFE integrator: 2nd-order IIR, 2-cycle latency, shadowed coefficients.
// Optional output clamping with a sticky flag is built when AFE_EMU_SATURATE_EN is defined.
module afe_integrator_emulator #(
  parameter int DW = 16,
  parameter int CW = 18,
  parameter int SW = 25
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          enable,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] x,
  output logic          out_valid,
  output logic [DW-1:0] y,
  input  logic          cfg_we,
  input  logic [2:0]    cfg_addr,
  input  logic [CW-1:0] cfg_data,
  input  logic          cfg_commit,
  output logic          cfg_busy,
  output logic          sat_flag
);
  localparam int AW   = 48;
  localparam int FRAC = CW - 3;        // Q3.15 coefficients
  localparam int XSH  = SW - DW;       // x joins the history scale as {x, XSH zeros}
  localparam int YLSB = FRAC + XSH;
  localparam int NC   = 5;
  localparam logic [NC-1:0][CW-1:0] COEF_DEF =
    {18'h38952, 18'h0F694, 18'h06F62, 18'h310BC, 18'h08000};

  typedef enum logic [1:0] {RESET_WAIT, RUN, APPLY, CLEAR} state_t;

  state_t state, state_nxt;
  logic   pending, pending_nxt, commit_req;

  assign cfg_busy   = pending | (state == APPLY) | (state == CLEAR);
  assign commit_req = cfg_commit & ~cfg_busy;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= RESET_WAIT;
      pending <= 1'b0;
    end else begin
      state   <= state_nxt;
      pending <= pending_nxt;
    end
  end

  // A commit waits for an idle input cycle so no accepted sample straddles the swap.
  always_comb begin
    state_nxt   = state;
    pending_nxt = pending;
    in_ready    = 1'b0;
    case (state)
      RESET_WAIT: begin
        state_nxt = RUN;
        if (commit_req) pending_nxt = 1'b1;
      end
      RUN: begin
        in_ready = 1'b1;
        if ((commit_req || pending) && !in_valid) begin
          state_nxt   = APPLY;
          pending_nxt = 1'b0;
        end else if (commit_req) begin
          pending_nxt = 1'b1;
        end
      end
      APPLY:   state_nxt = CLEAR;
      CLEAR:   state_nxt = RUN;
      default: state_nxt = RESET_WAIT;
    endcase
  end

  logic [NC-1:0][CW-1:0] act_c, shd_c;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      act_c <= COEF_DEF;
      shd_c <= COEF_DEF;
    end else begin
      if (state == APPLY) act_c <= shd_c;
      if (cfg_we && cfg_addr < 3'd5) shd_c[cfg_addr] <= cfg_data;
    end
  end

  function automatic logic signed [AW-1:0] mac(input logic [CW-1:0] c,
                                               input logic signed [SW-1:0] h);
    return AW'($signed(c)) * AW'(h);
  endfunction

  logic                 take, en_d, rise;
  logic [2:1]           vld_pipe;
  logic signed [SW-1:0] xs, x1, x2, y1, y2, hx1, hx2, hy1, hy2;
  logic signed [AW-1:0] acc, byp_acc, s1_acc;

  assign take = in_valid & in_ready;
  assign rise = enable & ~en_d;
  assign xs   = {x, {XSH{1'b0}}};
  // A rising enable starts the filter from rest, including the sample taken on that cycle.
  assign hx1  = rise ? '0 : x1;
  assign hx2  = rise ? '0 : x2;
  assign hy1  = rise ? '0 : y1;
  assign hy2  = rise ? '0 : y2;

  assign acc = mac(act_c[0], xs) + mac(act_c[1], hx1) + mac(act_c[2], hx2)
             + mac(act_c[3], hy1) + mac(act_c[4], hy2);
  // Bypass rides the same stage-2 path: x placed where y is extracted from acc.
  assign byp_acc = AW'($signed(x)) <<< YLSB;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_pipe <= '0;
      en_d     <= 1'b0;
      s1_acc   <= '0;
      x1       <= '0;
      x2       <= '0;
      y1       <= '0;
      y2       <= '0;
    end else begin
      en_d     <= enable;
      vld_pipe <= {vld_pipe[1], take};
      if (take) s1_acc <= enable ? acc : byp_acc;
      if (state == CLEAR || (rise && !take)) begin
        x1 <= '0;
        x2 <= '0;
        y1 <= '0;
        y2 <= '0;
      end else if (take && enable) begin
        x1 <= xs;
        x2 <= hx1;
        y1 <= acc[FRAC+SW-1:FRAC];
        y2 <= hy1;
      end
    end
  end

  logic [DW-1:0] y_nxt;
  logic          unused_acc;

`ifdef AFE_EMU_SATURATE_EN
  logic sat_hit;

  // Any acc outside the signed window ending at the y MSB is unrepresentable in y.
  assign sat_hit = ~(&s1_acc[AW-1:YLSB+DW-1] | ~|s1_acc[AW-1:YLSB+DW-1]);
  assign y_nxt   = !sat_hit      ? s1_acc[YLSB+DW-1:YLSB] :
                   s1_acc[AW-1]  ? {1'b1, {(DW-1){1'b0}}} :
                                   {1'b0, {(DW-1){1'b1}}};
  assign unused_acc = ^s1_acc[YLSB-1:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                 sat_flag <= 1'b0;
    else if (state == APPLY)      sat_flag <= 1'b0;
    else if (vld_pipe[1] && sat_hit) sat_flag <= 1'b1;
  end
`else
  assign y_nxt      = s1_acc[YLSB+DW-1:YLSB];
  assign sat_flag   = 1'b0;
  assign unused_acc = ^{s1_acc[AW-1:YLSB+DW], s1_acc[YLSB-1:0]};
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)         y <= '0;
    else if (vld_pipe[1]) y <= y_nxt;
  end

  assign out_valid = vld_pipe[2];

endmodule
